// File: rtl/c2c_arbiter_if.sv
//==============================================================================
// Module      : pipeline (package), c2c_data (interface)
// Description : Core-to-cache data port bundle shared by requesters and cache.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package pipeline;
    localparam int XLEN = 32;
endpackage

interface c2c_data;
    logic                          re;
    logic                          we;
    logic [pipeline::XLEN/8-1:0]   sel;
    logic [pipeline::XLEN-1:0]     addr;
    logic [pipeline::XLEN-1:0]     data_w;
    logic                          ack;
    logic [pipeline::XLEN-1:0]     data_r;

    modport master (
        output re, we, sel, addr, data_w,
        input  ack, data_r
    );

    modport slave (
        input  re, we, sel, addr, data_w,
        output ack, data_r
    );
endinterface

`default_nettype wire

// File: rtl/c2c_arbiter.sv
//==============================================================================
// Module      : c2c_arbiter
// Description : Two-requester arbiter sharing one core-to-cache data port.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module c2c_arbiter #(
    parameter int FAIR = 1
) (
    input  wire logic clk,
    input  wire logic rst_n,
    c2c_data.slave    m0,
    c2c_data.slave    m1,
    c2c_data.master   s
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   r_last;
    logic   w_req0;
    logic   w_req1;
    logic   w_grant_vld;
    logic   w_grant_idx;

    assign w_req0 = m0.re | m0.we;
    assign w_req1 = m1.re | m1.we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_next;
            if (w_grant_vld && s.ack) begin
                r_last <= w_grant_idx;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_grant_vld = 1'b0;
        w_grant_idx = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req0 && w_req1) begin
                    w_grant_vld = 1'b1;
                    w_grant_idx = (FAIR != 0) ? ~r_last : 1'b0;
                end else if (w_req0) begin
                    w_grant_vld = 1'b1;
                    w_grant_idx = 1'b0;
                end else if (w_req1) begin
                    w_grant_vld = 1'b1;
                    w_grant_idx = 1'b1;
                end
                // An ack in the request cycle completes it without locking.
                if (w_grant_vld && !s.ack) begin
                    w_next = w_grant_idx ? OWN1 : OWN0;
                end
            end
            OWN0: begin
                w_grant_vld = 1'b1;
                w_grant_idx = 1'b0;
                if (s.ack) w_next = IDLE;
            end
            OWN1: begin
                w_grant_vld = 1'b1;
                w_grant_idx = 1'b1;
                if (s.ack) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        // Reset silences the cache port immediately, not at the next edge.
        if (!rst_n) begin
            w_grant_vld = 1'b0;
            w_next      = IDLE;
        end
    end

    always_comb begin
        s.re     = 1'b0;
        s.we     = 1'b0;
        s.sel    = '0;
        s.addr   = '0;
        s.data_w = '0;
        if (w_grant_vld) begin
            if (w_grant_idx) begin
                s.re     = m1.re;
                s.we     = m1.we;
                s.sel    = m1.sel;
                s.addr   = m1.addr;
                s.data_w = m1.data_w;
            end else begin
                s.re     = m0.re;
                s.we     = m0.we;
                s.sel    = m0.sel;
                s.addr   = m0.addr;
                s.data_w = m0.data_w;
            end
        end
    end

    assign m0.ack    = s.ack & w_grant_vld & ~w_grant_idx;
    assign m1.ack    = s.ack & w_grant_vld &  w_grant_idx;
    assign m0.data_r = s.data_r;
    assign m1.data_r = s.data_r;

`ifndef SYNTHESIS
    a_owner_holds_req: assert property (@(posedge clk) disable iff (!rst_n)
        ((r_state == OWN0) |-> w_req0) and ((r_state == OWN1) |-> w_req1))
        else $error("c2c_arbiter: owner dropped its request before ack");
`endif

endmodule

`default_nettype wire

// File: tb/tb_c2c_arbiter.sv
//==============================================================================
// Module      : tb_c2c_arbiter
// Description : Directed self-checking bench for c2c_arbiter (FAIR=1 and FAIR=0).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_c2c_arbiter;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    c2c_data m0_if ();
    c2c_data m1_if ();
    c2c_data s_if  ();
    c2c_data fm0_if ();
    c2c_data fm1_if ();
    c2c_data fs_if  ();

    c2c_arbiter #(.FAIR(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .m0    (m0_if),
        .m1    (m1_if),
        .s     (s_if)
    );

    c2c_arbiter #(.FAIR(0)) dut_fp (
        .clk   (clk),
        .rst_n (rst_n),
        .m0    (fm0_if),
        .m1    (fm1_if),
        .s     (fs_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_all();
        m0_if.re = 0; m0_if.we = 0; m0_if.sel = '0; m0_if.addr = '0; m0_if.data_w = '0;
        m1_if.re = 0; m1_if.we = 0; m1_if.sel = '0; m1_if.addr = '0; m1_if.data_w = '0;
        s_if.ack = 0; s_if.data_r = '0;
        fm0_if.re = 0; fm0_if.we = 0; fm0_if.sel = '0; fm0_if.addr = '0; fm0_if.data_w = '0;
        fm1_if.re = 0; fm1_if.we = 0; fm1_if.sel = '0; fm1_if.addr = '0; fm1_if.data_w = '0;
        fs_if.ack = 0; fs_if.data_r = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        idle_all();
        tick();

        // Reset state (checked while reset is still held)
        settle();
        chk("rst_state", dut.r_state, 2'd0);
        chk("rst_last", dut.r_last, 1'b1);
        chk("rst_s_re", s_if.re, 1'b0);
        chk("rst_s_addr", s_if.addr, 32'h0);
        chk("rst_m0_ack", m0_if.ack, 1'b0);
        chk("rst_m1_ack", m1_if.ack, 1'b0);
        rst_n = 1'b1;
        tick();

        // Single requester m0, ack two cycles later
        m0_if.re = 1; m0_if.sel = 4'hF; m0_if.addr = 32'h100;
        settle();
        chk("t1_c0_addr", s_if.addr, 32'h100);
        chk("t1_c0_re", s_if.re, 1'b1);
        chk("t1_c0_sel", s_if.sel, 4'hF);
        chk("t1_c0_m0ack", m0_if.ack, 1'b0);
        tick();
        settle();
        chk("t1_c1_state", dut.r_state, 2'd1);
        chk("t1_c1_addr", s_if.addr, 32'h100);
        chk("t1_c1_m1ack", m1_if.ack, 1'b0);
        tick();
        s_if.ack = 1; s_if.data_r = 32'hDEADBEEF;
        settle();
        chk("t1_c2_m0ack", m0_if.ack, 1'b1);
        chk("t1_c2_data", m0_if.data_r, 32'hDEADBEEF);
        chk("t1_c2_m1ack", m1_if.ack, 1'b0);
        tick();
        idle_all();
        settle();
        chk("t1_end_state", dut.r_state, 2'd0);
        chk("t1_end_last", dut.r_last, 1'b0);
        chk("t1_end_addr", s_if.addr, 32'h0);

        // Simultaneous requests after reset: m0 first, then m1
        do_reset();
        m0_if.re = 1; m0_if.addr = 32'h10;
        m1_if.we = 1; m1_if.addr = 32'h20; m1_if.data_w = 32'h55;
        settle();
        chk("t2_c0_addr", s_if.addr, 32'h10);
        chk("t2_c0_we", s_if.we, 1'b0);
        tick();
        s_if.ack = 1;
        settle();
        chk("t2_c1_m0ack", m0_if.ack, 1'b1);
        chk("t2_c1_m1ack", m1_if.ack, 1'b0);
        tick();
        m0_if.re = 0; m0_if.addr = '0; s_if.ack = 0;
        settle();
        chk("t2_c2_addr", s_if.addr, 32'h20);
        chk("t2_c2_we", s_if.we, 1'b1);
        chk("t2_c2_re", s_if.re, 1'b0);
        chk("t2_c2_dw", s_if.data_w, 32'h55);
        tick();
        s_if.ack = 1;
        settle();
        chk("t2_c3_state", dut.r_state, 2'd2);
        chk("t2_c3_m1ack", m1_if.ack, 1'b1);
        chk("t2_c3_m0ack", m0_if.ack, 1'b0);
        tick();
        idle_all();
        settle();
        chk("t2_end_last", dut.r_last, 1'b1);
        chk("t2_end_state", dut.r_state, 2'd0);

        // Grant lock: m1 owns with 3 wait cycles, m0 arrives in wait 1
        m1_if.we = 1; m1_if.addr = 32'h300; m1_if.data_w = 32'h7;
        settle();
        chk("t3_c0_addr", s_if.addr, 32'h300);
        tick();
        m0_if.re = 1; m0_if.addr = 32'h400;
        settle();
        chk("t3_w1_addr", s_if.addr, 32'h300);
        chk("t3_w1_m0ack", m0_if.ack, 1'b0);
        tick();
        settle();
        chk("t3_w2_addr", s_if.addr, 32'h300);
        tick();
        settle();
        chk("t3_w3_addr", s_if.addr, 32'h300);
        tick();
        s_if.ack = 1;
        settle();
        chk("t3_ack_addr", s_if.addr, 32'h300);
        chk("t3_ack_m1ack", m1_if.ack, 1'b1);
        chk("t3_ack_m0ack", m0_if.ack, 1'b0);
        tick();
        m1_if.we = 0; m1_if.addr = '0; m1_if.data_w = '0;
        settle();
        chk("t3_next_addr", s_if.addr, 32'h400);
        chk("t3_next_re", s_if.re, 1'b1);
        chk("t3_next_m0ack", m0_if.ack, 1'b1);
        tick();
        idle_all();

        // Fairness: continuous contention, single-cycle completions
        do_reset();
        m0_if.re = 1; m0_if.addr = 32'hA0;
        m1_if.re = 1; m1_if.addr = 32'hB0;
        s_if.ack = 1;
        fm0_if.re = 1; fm0_if.addr = 32'hA0;
        fm1_if.re = 1; fm1_if.addr = 32'hB0;
        fs_if.ack = 1;
        for (int i = 0; i < 6; i++) begin
            settle();
            chk($sformatf("t4_rr%0d_m0ack", i), m0_if.ack, ((i % 2) == 0) ? 1'b1 : 1'b0);
            chk($sformatf("t4_rr%0d_m1ack", i), m1_if.ack, ((i % 2) == 1) ? 1'b1 : 1'b0);
            chk($sformatf("t4_rr%0d_addr", i), s_if.addr, ((i % 2) == 0) ? 32'hA0 : 32'hB0);
            chk($sformatf("t4_fp%0d_m0ack", i), fm0_if.ack, 1'b1);
            chk($sformatf("t4_fp%0d_m1ack", i), fm1_if.ack, 1'b0);
            tick();
        end
        idle_all();

        // Same-cycle ack: m0 then m1 alone, cache acks combinationally
        m0_if.re = 1; m0_if.addr = 32'h50; s_if.ack = 1;
        settle();
        chk("t5a_m0ack", m0_if.ack, 1'b1);
        tick();
        idle_all();
        settle();
        chk("t5a_state", dut.r_state, 2'd0);
        chk("t5a_last", dut.r_last, 1'b0);
        tick();
        m1_if.we = 1; m1_if.addr = 32'h60; s_if.ack = 1;
        settle();
        chk("t5b_m1ack", m1_if.ack, 1'b1);
        chk("t5b_m0ack", m0_if.ack, 1'b0);
        tick();
        idle_all();
        settle();
        chk("t5b_state", dut.r_state, 2'd0);
        chk("t5b_last", dut.r_last, 1'b1);
        tick();

        // Reset during OWN0 wait
        m1_if.we = 1; m1_if.addr = 32'h70; s_if.ack = 1;
        tick();
        idle_all();
        tick();
        m0_if.re = 1; m0_if.addr = 32'h600;
        tick();
        settle();
        chk("t6_own0", dut.r_state, 2'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_addr", s_if.addr, 32'h0);
        chk("t6_rst_re", s_if.re, 1'b0);
        chk("t6_rst_state", dut.r_state, 2'd0);
        tick();
        rst_n = 1'b1;
        idle_all();
        tick();
        m0_if.re = 1; m0_if.addr = 32'h610;
        m1_if.re = 1; m1_if.addr = 32'h620;
        s_if.ack = 1;
        settle();
        chk("t6_post_m0ack", m0_if.ack, 1'b1);
        chk("t6_post_m1ack", m1_if.ack, 1'b0);
        chk("t6_post_addr", s_if.addr, 32'h610);
        tick();
        idle_all();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
